// File: rtl/alu_pkg.sv
// Shared definitions for the approximate-ALU issue front end: opcodes,
// base latency, FSM state encoding, operation record and the correction
// length predictor.
package alu_pkg;

    localparam logic [2:0] SEL_ADD    = 3'b000;
    localparam logic [2:0] SEL_MUL    = 3'b001;
    localparam logic [2:0] SEL_BUBBLE = 3'b111;

    // Cycles from issue to a valid ALU result when no correction is needed
    localparam int BASE_LAT = 2;

    // Width of one buffered operation {sel,b,a}
    localparam int OP_W = 35;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]  sel;
        logic [15:0] b;
        logic [15:0] a;
    } op_t;

    // Predicted number of correction cycles the ALU will spend on an operation
    function automatic logic [1:0] corr_steps(input logic [15:0] a,
                                              input logic [15:0] b,
                                              input logic [2:0]  sel);
        logic       e0;
        logic       e1;
        logic       al;
        logic       ah;
        logic       bl;
        logic       bh;
        logic [1:0] k;
        e0 = a[0] & b[0];
        e1 = a[1] & b[1];
        al = a[0] & a[1];
        ah = a[2] & a[3];
        bl = b[0] & b[1];
        bh = b[2] & b[3];
        k  = 2'd0;
        case (sel)
            SEL_ADD: begin
                case ({e0, e1})
                    2'b00:   k = 2'd0;
                    2'b01:   k = 2'd1;
                    2'b10:   k = 2'd2;
                    2'b11:   k = 2'd1;
                    default: k = 2'd0;
                endcase
            end
            SEL_MUL: begin
                if ((al | ah) & (bl | bh)) begin
                    k = 2'd1;
                end else begin
                    k = 2'd0;
                end
            end
            default: k = 2'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_op_fifo.sv
// Small synchronous FIFO of operation records. Full/empty come from a
// registered occupancy count, so a full FIFO refuses pushes even in a
// cycle where it is also being popped.
module op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 35
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign rdata_o   = mem_q[rd_ptr_q];

    // Occupancy update from the accepted push/pop pair
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side front end for the error-correcting approximate ALU. Buffers
// operations, issues one at a time while the ALU sequencer is idle, waits
// the predicted 2+k cycles, captures the result and hands it downstream.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [2:0]       in_sel,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [2:0]       alu_sel,
    input  logic [16:0]      alu_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [16:0]      out_y,
    output logic [2:0]       out_sel,
    output logic [CNT_W-1:0] corr_cnt
);

    state_e            state_q;
    state_e            state_d;
    logic [1:0]        wcnt_q;
    logic [1:0]        wcnt_d;
    logic [15:0]       alu_a_q;
    logic [15:0]       alu_a_d;
    logic [15:0]       alu_b_q;
    logic [15:0]       alu_b_d;
    logic [2:0]        alu_sel_q;
    logic [2:0]        alu_sel_d;
    logic [2:0]        iss_sel_q;
    logic [2:0]        iss_sel_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [16:0]       out_y_q;
    logic [16:0]       out_y_d;
    logic [2:0]        out_sel_q;
    logic [2:0]        out_sel_d;
    logic [CNT_W-1:0]  corr_cnt_q;
    logic [CNT_W-1:0]  corr_cnt_d;

    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              push_s;
    logic              pop_s;
    logic              issue_s;
    logic [1:0]        k_s;
    op_t               head_s;
    op_t               push_op_s;

    assign in_ready  = ~fifo_full_s;
    assign push_s    = in_valid & ~fifo_full_s;
    assign push_op_s = {in_sel, in_b, in_a};
    assign k_s       = corr_steps(head_s.a, head_s.b, head_s.sel);
    // A result still waiting downstream blocks the next issue, so the
    // capture register can never be overwritten while full.
    assign issue_s   = (state_q == ST_IDLE) & ~fifo_empty_s & ~out_valid_q;

    op_fifo #(
        .DEPTH (DEPTH),
        .W     (OP_W)
    ) u_op_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .wdata_i (push_op_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 2'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: issue, wait countdown, capture and handshake
    always_comb begin
        pop_s       = 1'b0;
        alu_a_d     = 16'd0;
        alu_b_d     = 16'd0;
        alu_sel_d   = SEL_BUBBLE;
        wcnt_d      = wcnt_q;
        iss_sel_d   = iss_sel_q;
        out_y_d     = out_y_q;
        out_sel_d   = out_sel_q;
        corr_cnt_d  = corr_cnt_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (issue_s) begin
                    pop_s     = 1'b1;
                    alu_a_d   = head_s.a;
                    alu_b_d   = head_s.b;
                    alu_sel_d = head_s.sel;
                    iss_sel_d = head_s.sel;
                    wcnt_d    = 2'(BASE_LAT - 1) + k_s;
                    if ((k_s != 2'd0) && (corr_cnt_q != {CNT_W{1'b1}})) begin
                        corr_cnt_d = corr_cnt_q + CNT_W'(1);
                    end else begin
                        corr_cnt_d = corr_cnt_q;
                    end
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (wcnt_q != 2'd0) begin
                    wcnt_d = wcnt_q - 2'd1;
                end else begin
                    wcnt_d = wcnt_q;
                end
            end
            ST_CAPTURE: begin
                out_y_d     = alu_y;
                out_sel_d   = iss_sel_q;
                out_valid_d = 1'b1;
            end
            default: begin
                wcnt_d = 2'd0;
            end
        endcase
    end

    // Datapath registers; the ALU operands revert to a bubble after one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q      <= 2'd0;
            alu_a_q     <= 16'd0;
            alu_b_q     <= 16'd0;
            alu_sel_q   <= SEL_BUBBLE;
            iss_sel_q   <= 3'd0;
            out_valid_q <= 1'b0;
            out_y_q     <= 17'd0;
            out_sel_q   <= 3'd0;
            corr_cnt_q  <= '0;
        end else begin
            wcnt_q      <= wcnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            iss_sel_q   <= iss_sel_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_sel_q   <= out_sel_d;
            corr_cnt_q  <= corr_cnt_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_sel   = out_sel_q;
    assign corr_cnt  = corr_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a stub ALU and a result scoreboard.
// corr_cnt is built 2 bits wide so saturation is reached in a few ops.
module tb_alu_issue_ctrl;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_a = 16'd0;
    logic [15:0]   in_b = 16'd0;
    logic [2:0]    in_sel = 3'd0;
    logic [15:0]   alu_a;
    logic [15:0]   alu_b;
    logic [2:0]    alu_sel;
    logic [16:0]   alu_y = 17'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [16:0]   out_y;
    logic [2:0]    out_sel;
    logic [CW-1:0] corr_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [16:0] y;
        logic [2:0]  sel;
    } exp_t;
    exp_t exp_q [$];

    alu_issue_ctrl #(.DEPTH(4), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sel    (in_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_sel   (out_sel),
        .corr_cnt  (corr_cnt)
    );

    always #5 clk = ~clk;

    // Reference correction length, written from the operation rules
    function automatic logic [1:0] tb_k(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] sel);
        logic e0, e1;
        if (sel == 3'b000) begin
            e0 = a[0] & b[0];
            e1 = a[1] & b[1];
            if (e1) return 2'd1;
            else if (e0) return 2'd2;
            else return 2'd0;
        end else if (sel == 3'b001) begin
            if (((a[0] & a[1]) | (a[2] & a[3])) && ((b[0] & b[1]) | (b[2] & b[3])))
                return 2'd1;
            else
                return 2'd0;
        end else begin
            return 2'd0;
        end
    endfunction

    // Reference ALU result
    function automatic logic [16:0] ref_res(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] sel);
        logic [31:0] p;
        p = {16'd0, a} * {16'd0, b};
        if (sel == 3'b001) return p[16:0];
        else return {1'b0, a} + {1'b0, b};
    endfunction

    // Stub ALU: result valid for one cycle at issue+2+k, zero otherwise
    logic [1:0]  stub_cnt = 2'd0;
    logic [16:0] stub_res = 17'd0;
    always @(posedge clk) begin
        if (stub_cnt == 2'd0) begin
            alu_y <= 17'd0;
            if (alu_sel != 3'b111) begin
                stub_cnt <= tb_k(alu_a, alu_b, alu_sel) + 2'd1;
                stub_res <= ref_res(alu_a, alu_b, alu_sel);
            end
        end else if (stub_cnt == 2'd1) begin
            alu_y    <= stub_res;
            stub_cnt <= 2'd0;
        end else begin
            alu_y    <= 17'd0;
            stub_cnt <= stub_cnt - 2'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Compare the presented result against the oldest expected entry
    task automatic check_head(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_result"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_out_y"}, {15'd0, out_y}, {15'd0, e.y});
            chk({tag, "_out_sel"}, {29'd0, out_sel}, {29'd0, e.sel});
        end
    endtask

    // Single accepted push; caller sits #1 after a rising edge
    task automatic push_one(input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] sel, input bit record);
        exp_t e;
        chk("push_in_ready", {31'd0, in_ready}, 32'd1);
        in_a = a; in_b = b; in_sel = sel; in_valid = 1'b1;
        if (record) begin
            e.y = ref_res(a, b, sel);
            e.sel = sel;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // One op through an empty idle block with out_ready high
    task automatic run_single(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic [2:0] sel, input int k, input int exp_cnt);
        int n;
        out_ready = 1'b1;
        push_one(a, b, sel, 1'b1);
        @(posedge clk); #1;
        chk({tag, "_issue_a"}, {16'd0, alu_a}, {16'd0, a});
        chk({tag, "_issue_b"}, {16'd0, alu_b}, {16'd0, b});
        chk({tag, "_issue_sel"}, {29'd0, alu_sel}, {29'd0, sel});
        @(posedge clk); #1;
        chk({tag, "_bubble_sel"}, {29'd0, alu_sel}, 32'd7);
        chk({tag, "_bubble_a"}, {16'd0, alu_a}, 32'd0);
        n = 2;
        while (out_valid !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 4 + k);
        check_head(tag);
        chk({tag, "_corr_cnt"}, {30'd0, corr_cnt}, exp_cnt);
        @(posedge clk); #1;
        chk({tag, "_consumed"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        // Reset state
        #22;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_y", {15'd0, out_y}, 32'd0);
        chk("rst_out_sel", {29'd0, out_sel}, 32'd0);
        chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
        chk("rst_alu_sel", {29'd0, alu_sel}, 32'd7);
        chk("rst_corr_cnt", {30'd0, corr_cnt}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // add 1+2: no carry-risk bits, k=0
        run_single("add_1_2", 16'd1, 16'd2, 3'b000, 0, 0);
        // add 2+2: bit1 pair set, k=1
        run_single("add_2_2", 16'd2, 16'd2, 3'b000, 1, 1);
        // add 3+1: only bit0 pair set, k=2
        run_single("add_3_1", 16'd3, 16'd1, 3'b000, 2, 2);
        // mul 3*4: b=0100 has neither low nor high pair, k=0
        run_single("mul_3_4", 16'd3, 16'd4, 3'b001, 0, 2);
        // mul 3*3: both low pairs set, k=1
        run_single("mul_3_3", 16'd3, 16'd3, 3'b001, 1, 3);
        // mul 1*1: a low pair incomplete, k=0
        run_single("mul_1_1", 16'd1, 16'd1, 3'b001, 0, 3);
        // counter already all-ones: a k=1 op leaves it saturated
        run_single("sat", 16'd2, 16'd2, 3'b000, 1, 3);

        // Back-pressure: one result held, then fill the FIFO
        out_ready = 1'b0;
        push_one(16'd5, 16'd6, 3'b000, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_result_ready", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_a = 16'(10 + i); in_b = 16'(i); in_sel = 3'b000; in_valid = 1'b1;
            chk("fill_in_ready", {31'd0, in_ready}, (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) begin
                exp_q.push_back('{ref_res(in_a, in_b, 3'b000), 3'b000});
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_out_y", {15'd0, out_y}, 32'd11);
            chk("hold_no_issue", {29'd0, alu_sel}, 32'd7);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            if (out_valid === 1'b1) begin
                check_head("drain");
            end
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", {31'd0, (exp_q.size() == 0)}, 32'd1);
        chk("drain_ready", {31'd0, in_ready}, 32'd1);

        // Reset during WAIT of a k=2 op
        push_one(16'd3, 16'd1, 3'b000, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_sel", {29'd0, alu_sel}, 32'd7);
        chk("mid_rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("mid_rst_alu_b", {16'd0, alu_b}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_y", {15'd0, out_y}, 32'd0);
        chk("mid_rst_out_sel", {29'd0, out_sel}, 32'd0);
        chk("mid_rst_corr_cnt", {30'd0, corr_cnt}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
            chk("post_rst_bubble", {29'd0, alu_sel}, 32'd7);
        end

        // Normal operation resumes after reset
        run_single("after_rst", 16'd1, 16'd2, 3'b000, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
